shot_trigger: RTL
=================

// Module: shot_trigger
// PURPOSE
//  Converts the raw player fire key into single-clock shooting_pulse strobes for the missile pool.
//  Sits directly upstream of the missile block and feeds its shooting pulse input.
//  Provides debounce, press-and-hold autofire, and a finite magazine with a timed reload.
//  All game-time decisions are taken on startOfFrame; only the input synchroniser runs every clock.
// PARAMETERS
//  DEBOUNCE_FRAMES  2   consecutive equal frame samples required before key_stable changes
//  AUTOFIRE_DELAY   20  frames the key is held after the first shot before autofire starts
//  AUTOFIRE_PERIOD  8   frames between autofire shots (>=1)
//  MAG_SIZE         7   shots per magazine; equals the missile pool size
//  RELOAD_FRAMES    60  frames spent reloading once the magazine is empty
//  CNT_WIDTH        8   width of the frame counters; every *_FRAMES/DELAY/PERIOD value is < 2**CNT_WIDTH
// PORTS
//  clk             in   1   system clock (single clock domain)
//  resetN          in   1   asynchronous active-low reset
//  startOfFrame    in   1   one-clk strobe per video frame
//  fire_key        in   1   raw, asynchronous, bouncy fire key level (1 = pressed)
//  enable          in   1   game running; 0 blocks new shots
//  shooting_pulse  out  1   one-clk fire strobe to the missile pool
//  ammo_left       out  $clog2(MAG_SIZE+1)   shots remaining in the magazine
//  reloading       out  1   high while in RELOAD
// BEHAVIOUR
//  Reset: sync flops=0, key_stable=0, key_prev=0, state=IDLE, all counters=0,
//   shooting_pulse=0, ammo_left=MAG_SIZE, reloading=0. Reset is legal mid-reload or mid-autofire.
//  Sync: 2-flop synchroniser fire_key->key_sync, updated every clk.
//  Debounce: on startOfFrame, key_stable takes key_sync only after DEBOUNCE_FRAMES equal consecutive samples.
//   key_prev latches key_stable on each startOfFrame. rise = key_stable & ~key_prev.
//  fire_req is evaluated on a startOfFrame clock. shooting_pulse is registered and goes high for exactly
//   one clk on the following clock. Latency from a clean press = 2 clk + DEBOUNCE_FRAMES frames + 1 clk.
//  Each fire decrements ammo_left in the same clock that shooting_pulse rises.
//  FSM (state_t), transitions only on startOfFrame:
//   IDLE  : rise & enable & ammo_left>0 -> fire, go HELD, hold_cnt=0.
//   HELD  : ~key_stable | ~enable -> IDLE. Otherwise, if hold_cnt==AUTOFIRE_DELAY-1 -> fire, go AUTO, rep_cnt=0.
//           Otherwise hold_cnt++.
//   AUTO  : ~key_stable | ~enable -> IDLE. Otherwise, if rep_cnt==AUTOFIRE_PERIOD-1 -> fire, rep_cnt=0.
//           Otherwise rep_cnt++.
//   RELOAD: rel_cnt++. When rel_cnt==RELOAD_FRAMES-1: ammo_left=MAG_SIZE, rel_cnt=0, go IDLE.
//           Ignores key and enable. A key held through the reload must be released and re-pressed.
//  A fire that takes ammo_left from 1 to 0 goes to RELOAD in the same transition, overriding HELD/AUTO.
//  reloading = (state==RELOAD), registered.
//  Simultaneous events:
//   - Release and an autofire due on the same frame: release wins, no shot.
//   - enable falling on a shot frame: no shot.
//   - No shot is ever issued in RELOAD or with ammo_left==0.
//  At most one shooting_pulse per frame. Counters never wrap; their values are bounded by the compare limits above.
// STRUCTURE
//  Package shot_pkg:
//   - typedef enum logic [1:0] {IDLE, HELD, AUTO, RELOAD} state_t
//   - default parameter constants
//  Sub-module frame_debouncer (#DEBOUNCE_FRAMES, CNT_WIDTH):
//   - contains the 2-flop synchroniser and the per-frame stability counter
//   - outputs key_stable
//  Top level holds the FSM, the three frame counters, the ammo register and the output registers.
// TESTING
//  1 Reset mid-AUTO with ammo_left=3: all outputs return to reset values; the next press fires normally.
//  2 Key bouncing 0/1 every 3 clk inside one frame, then held high for 3 frames (DEBOUNCE_FRAMES=2):
//    exactly one shooting_pulse, 1 clk wide, 1 clk after the 2nd stable startOfFrame.
//  3 Key held 40 frames (DELAY=20, PERIOD=8): pulses on frames 0, 20, 28, 36, then 4 shots, ammo_left=3.
//  4 Seven separate taps: 7 pulses, ammo_left reaches 0, reloading=1.
//    An 8th tap during reload gives no pulse.
//    After 60 frames: ammo_left=7, reloading=0.
//  5 Key held continuously through a reload: no pulse after reload. Release and re-press -> 1 pulse.
//  6 enable=0 during a press: no pulse and state stays IDLE.
//    Key released on the exact frame an autofire shot is due: no pulse.

Source files
------------

// File: rtl/shot_pkg.sv
// Shared types and default tuning constants for the fire-key to shooting-pulse path.
package shot_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        AUTO   = 2'd2,
        RELOAD = 2'd3
    } state_t;

    localparam int DEF_DEBOUNCE_FRAMES = 2;
    localparam int DEF_AUTOFIRE_DELAY  = 20;
    localparam int DEF_AUTOFIRE_PERIOD = 8;
    localparam int DEF_MAG_SIZE        = 7;
    localparam int DEF_RELOAD_FRAMES   = 60;
    localparam int DEF_CNT_WIDTH       = 8;

endpackage

// File: rtl/frame_debouncer.sv
// Two-flop synchroniser plus frame-rate debounce of the raw fire key.
// key_stable is the debounced level as of the current startOfFrame clock.
module frame_debouncer #(
    parameter int DEBOUNCE_FRAMES = 2,
    parameter int CNT_WIDTH       = 8
) (
    input  logic clk,
    input  logic resetN,
    input  logic sof,
    input  logic key_raw,
    output logic key_stable
);

    logic [1:0]           sync_q, sync_d;
    logic [CNT_WIDTH-1:0] stab_cnt_q, stab_cnt_d;
    logic                 key_stable_q, key_stable_d;

    // stab_cnt counts consecutive frame samples that disagree with the stable level
    always_comb begin
        sync_d       = {sync_q[0], key_raw};
        stab_cnt_d   = stab_cnt_q;
        key_stable_d = key_stable_q;
        if (sof) begin
            if (sync_q[1] != key_stable_q) begin
                if (stab_cnt_q == CNT_WIDTH'(DEBOUNCE_FRAMES - 1)) begin
                    key_stable_d = sync_q[1];
                    stab_cnt_d   = '0;
                end else begin
                    stab_cnt_d = stab_cnt_q + CNT_WIDTH'(1);
                end
            end else begin
                stab_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sync_q       <= '0;
            stab_cnt_q   <= '0;
            key_stable_q <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            stab_cnt_q   <= stab_cnt_d;
            key_stable_q <= key_stable_d;
        end
    end

    // Exposing the next value lets the shot decision use this frame's sample directly.
    assign key_stable = key_stable_d;

endmodule

// File: rtl/shot_trigger.sv
// Fire-key front end for the missile pool: debounce, press-and-hold autofire,
// finite magazine and timed reload. Game decisions are made only on startOfFrame.
module shot_trigger
    import shot_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES,
    parameter int AUTOFIRE_DELAY  = DEF_AUTOFIRE_DELAY,
    parameter int AUTOFIRE_PERIOD = DEF_AUTOFIRE_PERIOD,
    parameter int MAG_SIZE        = DEF_MAG_SIZE,
    parameter int RELOAD_FRAMES   = DEF_RELOAD_FRAMES,
    parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
    input  logic                           clk,
    input  logic                           resetN,
    input  logic                           startOfFrame,
    input  logic                           fire_key,
    input  logic                           enable,
    output logic                           shooting_pulse,
    output logic [$clog2(MAG_SIZE+1)-1:0]  ammo_left,
    output logic                           reloading
);

    localparam int AMMO_W = $clog2(MAG_SIZE + 1);

    logic key_stable;

    frame_debouncer #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
        .CNT_WIDTH       (CNT_WIDTH)
    ) u_debouncer (
        .clk        (clk),
        .resetN     (resetN),
        .sof        (startOfFrame),
        .key_raw    (fire_key),
        .key_stable (key_stable)
    );

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_WIDTH-1:0] rep_cnt_q, rep_cnt_d;
    logic [CNT_WIDTH-1:0] rel_cnt_q, rel_cnt_d;
    logic [AMMO_W-1:0]    ammo_q, ammo_d;
    logic                 key_prev_q, key_prev_d;
    logic                 shoot_q, shoot_d;
    logic                 reloading_q, reloading_d;
    logic                 rise;
    logic                 fire;

    assign rise = key_stable & ~key_prev_q;

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        rel_cnt_d   = rel_cnt_q;
        ammo_d      = ammo_q;
        key_prev_d  = key_prev_q;
        fire        = 1'b0;
        if (startOfFrame) begin
            key_prev_d = key_stable;
            case (state_q)
                IDLE: begin
                    if (rise && enable && (ammo_q != '0)) begin
                        fire       = 1'b1;
                        state_d    = HELD;
                        hold_cnt_d = '0;
                    end
                end
                HELD: begin
                    if (!key_stable || !enable) begin
                        state_d = IDLE;
                    end else if (hold_cnt_q == CNT_WIDTH'(AUTOFIRE_DELAY - 1)) begin
                        fire      = (ammo_q != '0);
                        state_d   = AUTO;
                        rep_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + CNT_WIDTH'(1);
                    end
                end
                AUTO: begin
                    if (!key_stable || !enable) begin
                        state_d = IDLE;
                    end else if (rep_cnt_q == CNT_WIDTH'(AUTOFIRE_PERIOD - 1)) begin
                        fire      = (ammo_q != '0);
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + CNT_WIDTH'(1);
                    end
                end
                RELOAD: begin
                    if (rel_cnt_q == CNT_WIDTH'(RELOAD_FRAMES - 1)) begin
                        ammo_d    = AMMO_W'(MAG_SIZE);
                        rel_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        rel_cnt_d = rel_cnt_q + CNT_WIDTH'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
            // The last round empties the magazine and forces a reload from any firing state
            if (fire) begin
                ammo_d = ammo_q - AMMO_W'(1);
                if (ammo_q == AMMO_W'(1)) begin
                    state_d = RELOAD;
                end
            end
        end
        shoot_d     = fire;
        reloading_d = (state_d == RELOAD);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            hold_cnt_q  <= '0;
            rep_cnt_q   <= '0;
            rel_cnt_q   <= '0;
            ammo_q      <= AMMO_W'(MAG_SIZE);
            key_prev_q  <= 1'b0;
            shoot_q     <= 1'b0;
            reloading_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            rel_cnt_q   <= rel_cnt_d;
            ammo_q      <= ammo_d;
            key_prev_q  <= key_prev_d;
            shoot_q     <= shoot_d;
            reloading_q <= reloading_d;
        end
    end

    assign shooting_pulse = shoot_q;
    assign ammo_left      = ammo_q;
    assign reloading      = reloading_q;

endmodule
